datapath_mc: RTL

- Parametrised multi-cycle successor of the fixed 8-bit datapath.
- Contains its own micro-sequencer (FETCH/DECODE/EXEC/MEM/WB), a parametrised register file, A/B/C operand latches, ALU, flag register and PC.
- Data memory is reached through a req/ack handshake that tolerates wait states. A single-cycle instruction ROM is external.
- Sits under the MCU top level in place of the datapath plus external control-unit pair.

---
 rtl/datapath_mc.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/datapath_mc.sv
// Multi-cycle core datapath: FETCH/DECODE/EXEC/MEM/WB sequencer, register file,
// A/B/C operand latches, ALU, flag register and PC; data memory over req/ack.
module datapath_mc #(
    parameter int DATA_W = 8,
    parameter int NREGS = 8,
    parameter int PC_W = 8,
    localparam int RA_W = $clog2(NREGS),
    localparam int INSTR_W = 4 + 3 * RA_W
) (
    input  logic               clk,
    input  logic               reset,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DATA_W-1:0]  dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic [DATA_W-1:0]  dmem_rdata,
    input  logic               dmem_ack,
    input  logic [DATA_W-1:0]  io_in,
    output logic [DATA_W-1:0]  io_out,
    output logic               io_strobe,
    output logic [PC_W-1:0]    pc_out,
    output logic [2:0]         flags,
    output logic               halted,
    output logic [2:0]         state_dbg
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SHL  = 4'd5;
    localparam logic [3:0] OP_SHR  = 4'd6;
    localparam logic [3:0] OP_NOT  = 4'd7;
    localparam logic [3:0] OP_MOV  = 4'd8;
    localparam logic [3:0] OP_LD   = 4'd9;
    localparam logic [3:0] OP_ST   = 4'd10;
    localparam logic [3:0] OP_IN   = 4'd11;
    localparam logic [3:0] OP_OUT  = 4'd12;
    localparam logic [3:0] OP_JZ   = 4'd13;
    localparam logic [3:0] OP_JMP  = 4'd14;
    localparam logic [3:0] OP_HALT = 4'd15;

    localparam int MSB = DATA_W - 1;

    state_t              state_q;
    state_t              state_d;
    logic [INSTR_W-1:0]  ir_q;
    logic [PC_W-1:0]     pc_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [DATA_W-1:0]   c_q;
    logic [DATA_W-1:0]   regs_q [NREGS];
    logic [2:0]          flags_q;
    logic [DATA_W-1:0]   io_out_q;
    logic                io_strobe_q;
    logic                req_q;
    logic                we_q;
    logic [DATA_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;

    logic [3:0]          op;
    logic [RA_W-1:0]     rd;
    logic [RA_W-1:0]     rs1;
    logic [RA_W-1:0]     rs2;

    assign op  = ir_q[INSTR_W-1 -: 4];
    assign rd  = ir_q[3*RA_W-1 -: RA_W];
    assign rs1 = ir_q[2*RA_W-1 -: RA_W];
    assign rs2 = ir_q[RA_W-1:0];

    // ALU works on the A/B latches; flags register is {overflow, carry, zero}.
    logic [DATA_W:0]     sum_w;
    logic [DATA_W:0]     diff_w;
    logic [DATA_W-1:0]   alu_res;
    logic                alu_c;
    logic                alu_v;
    logic                alu_upd;
    logic [PC_W-1:0]     jump_target;

    always_comb begin
        sum_w   = {1'b0, a_q} + {1'b0, b_q};
        diff_w  = {1'b0, a_q} - {1'b0, b_q};
        alu_res = a_q;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_upd = 1'b1;
        case (op)
            OP_ADD: begin
                alu_res = sum_w[MSB:0];
                alu_c   = sum_w[DATA_W];
                alu_v   = (a_q[MSB] == b_q[MSB]) && (sum_w[MSB] != a_q[MSB]);
            end
            OP_SUB: begin
                alu_res = diff_w[MSB:0];
                alu_c   = diff_w[DATA_W];
                alu_v   = (a_q[MSB] != b_q[MSB]) && (diff_w[MSB] != a_q[MSB]);
            end
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_XOR: alu_res = a_q ^ b_q;
            OP_SHL: begin
                alu_res = {a_q[MSB-1:0], 1'b0};
                alu_c   = a_q[MSB];
            end
            OP_SHR: begin
                alu_res = {1'b0, a_q[MSB:1]};
                alu_c   = a_q[0];
            end
            OP_NOT: alu_res = ~a_q;
            default: alu_upd = 1'b0;
        endcase
    end

    assign jump_target = PC_W'(a_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                case (op)
                    OP_LD, OP_ST:          state_d = S_MEM;
                    OP_IN:                 state_d = S_WB;
                    OP_OUT, OP_JZ, OP_JMP: state_d = S_FETCH;
                    OP_HALT:               state_d = S_HALT;
                    default:               state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (dmem_ack) begin
                    state_d = we_q ? S_FETCH : S_WB;
                end
            end
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    // Data-memory handshake: req, we, addr and wdata are registered together at
    // the EXEC edge and held unchanged until the cycle in which dmem_ack=1 is seen
    // in MEM; req drops on that edge. Acks arriving in any other state are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_q        <= '0;
            pc_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            flags_q     <= '0;
            io_out_q    <= '0;
            io_strobe_q <= 1'b0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            io_strobe_q <= 1'b0;
            case (state_q)
                S_FETCH: begin
                    ir_q <= imem_data;
                    pc_q <= pc_q + PC_W'(1);
                end
                S_DECODE: begin
                    a_q <= regs_q[rs1];
                    b_q <= regs_q[rs2];
                end
                S_EXEC: begin
                    if (op <= OP_MOV) begin
                        c_q <= alu_res;
                        if (alu_upd) begin
                            flags_q <= {alu_v, alu_c, (alu_res == '0)};
                        end
                    end else begin
                        case (op)
                            OP_LD, OP_ST: begin
                                req_q   <= 1'b1;
                                we_q    <= (op == OP_ST);
                                addr_q  <= b_q;
                                wdata_q <= a_q;
                            end
                            OP_IN:  c_q <= io_in;
                            OP_OUT: begin
                                io_out_q    <= a_q;
                                io_strobe_q <= 1'b1;
                            end
                            OP_JZ: begin
                                if (flags_q[0]) begin
                                    pc_q <= jump_target;
                                end
                            end
                            OP_JMP: pc_q <= jump_target;
                            default: ;
                        endcase
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        req_q <= 1'b0;
                        if (!we_q) begin
                            c_q <= dmem_rdata;
                        end
                    end
                end
                S_WB: regs_q[rd] <= c_q;
                default: ;
            endcase
        end
    end

    assign imem_addr  = pc_q;
    assign pc_out     = pc_q;
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign io_out     = io_out_q;
    assign io_strobe  = io_strobe_q;
    assign flags      = flags_q;
    assign halted     = (state_q == S_HALT);
    assign state_dbg  = state_q;

endmodule
